// File: rtl/debug_core_bridge.sv
// debug_core_bridge
//   Core-clock stage behind the JTAG debug module. It converts DM halt/resume
//   requests and abstract register accesses into the core's debug handshake:
//   haltreq/resumereq plus GPR/CSR index, write strobes and read-data capture.
//   Register accesses are only forwarded while the core is halted. Every other
//   request gets an error response, so the DM never hangs.
//
//   Ports
//     clk, rst_n                     core clock, asynchronous active-low reset
//     dm_halt_req_i                  level: DM wants the core halted
//     dm_resume_req_i                pulse: resume a halted core
//     dm_req_valid_i/ready_o         abstract register request handshake
//     dm_req_we_i/regno_i/wdata_i    request contents
//     dm_resp_valid_o/err_o/rdata_o  one-cycle response per accepted request
//     halted_o, halt_timeout_o       status back to the DM (timeout is sticky)
//     core_haltreq_o/resumereq_o     run-control requests to the core
//     core_halted_i                  core halted acknowledge
//     core_gprwr_o/csrwr_o           register write strobes
//     core_index_o, core_wdata_o     register index and write data
//     core_gprrdata_i/csrrdata_i     read data, valid one clock after the index
module debug_core_bridge #(
    parameter int DATA_BITS    = 32,
    parameter int REGNO_BITS   = 16,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dm_halt_req_i,
    input  logic                  dm_resume_req_i,
    input  logic                  dm_req_valid_i,
    output logic                  dm_req_ready_o,
    input  logic                  dm_req_we_i,
    input  logic [REGNO_BITS-1:0] dm_req_regno_i,
    input  logic [DATA_BITS-1:0]  dm_req_wdata_i,
    output logic                  dm_resp_valid_o,
    output logic                  dm_resp_err_o,
    output logic [DATA_BITS-1:0]  dm_resp_rdata_o,
    output logic                  halted_o,
    output logic                  halt_timeout_o,
    output logic                  core_haltreq_o,
    output logic                  core_resumereq_o,
    input  logic                  core_halted_i,
    output logic                  core_gprwr_o,
    output logic                  core_csrwr_o,
    output logic [11:0]           core_index_o,
    output logic [DATA_BITS-1:0]  core_wdata_o,
    input  logic [DATA_BITS-1:0]  core_gprrdata_i,
    input  logic [DATA_BITS-1:0]  core_csrrdata_i
);

    typedef enum logic [2:0] {
        ST_RUN         = 3'd0,
        ST_HALT_WAIT   = 3'd1,
        ST_HALTED      = 3'd2,
        ST_ACCESS      = 3'd3,
        ST_READ_WAIT   = 3'd4,
        ST_RESUME_WAIT = 3'd5
    } state_e;

    localparam logic [REGNO_BITS-1:0] GPR_BASE    = REGNO_BITS'(16'h1000);
    localparam logic [7:0]            TIMEOUT_CNT = 8'(HALT_TIMEOUT);

    // GPR window is GPR_BASE .. GPR_BASE+31 (x0..x31).
    function automatic logic is_gpr(input logic [REGNO_BITS-1:0] regno);
        is_gpr = (regno[REGNO_BITS-1:5] == GPR_BASE[REGNO_BITS-1:5]);
    endfunction

    // CSR window is 0x000 .. 0xFFF.
    function automatic logic is_csr(input logic [REGNO_BITS-1:0] regno);
        is_csr = (regno[REGNO_BITS-1:12] == '0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        if (cnt == 8'hFF) begin
            sat_inc = cnt;
        end else begin
            sat_inc = cnt + 8'd1;
        end
    endfunction

    state_e                 state_r;
    logic [7:0]             cnt_r;
    logic                   we_r;
    logic                   gpr_sel_r;
    logic                   ready_r;
    logic                   resp_valid_r;
    logic                   resp_err_r;
    logic [DATA_BITS-1:0]   resp_rdata_r;
    logic                   halted_r;
    logic                   timeout_r;
    logic                   haltreq_r;
    logic                   resumereq_r;
    logic                   gprwr_r;
    logic                   csrwr_r;
    logic [11:0]            index_r;
    logic [DATA_BITS-1:0]   wdata_r;

    logic                   req_accept_s;
    logic                   regno_gpr_s;
    logic                   regno_ok_s;

    assign req_accept_s = dm_req_valid_i && ready_r;
    assign regno_gpr_s  = is_gpr(dm_req_regno_i);
    assign regno_ok_s   = regno_gpr_s || is_csr(dm_req_regno_i);

    // Run-control / register-access FSM with all DM- and core-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            cnt_r        <= 8'd0;
            we_r         <= 1'b0;
            gpr_sel_r    <= 1'b0;
            ready_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
            halted_r     <= 1'b0;
            timeout_r    <= 1'b0;
            haltreq_r    <= 1'b0;
            resumereq_r  <= 1'b0;
            gprwr_r      <= 1'b0;
            csrwr_r      <= 1'b0;
            index_r      <= 12'd0;
            wdata_r      <= '0;
        end else begin
            // Pulses default low. The counter only survives while a wait state
            // is held, which clears it on every state entry. Ready is high
            // except on the way into the busy states.
            cnt_r        <= 8'd0;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
            gprwr_r      <= 1'b0;
            csrwr_r      <= 1'b0;

            case (state_r)
                ST_RUN: begin
                    if (req_accept_s) begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                    end else begin
                        resp_valid_r <= 1'b0;
                    end
                    if (dm_halt_req_i) begin
                        state_r   <= ST_HALT_WAIT;
                        haltreq_r <= 1'b1;
                    end else begin
                        state_r   <= ST_RUN;
                    end
                end

                ST_HALT_WAIT: begin
                    if (req_accept_s) begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                    end else begin
                        resp_valid_r <= 1'b0;
                    end
                    // An acknowledged halt wins over a dropped halt request.
                    if (core_halted_i) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end else if (!dm_halt_req_i) begin
                        state_r   <= ST_RUN;
                        haltreq_r <= 1'b0;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                        if (sat_inc(cnt_r) == TIMEOUT_CNT) begin
                            timeout_r <= 1'b1;
                        end else begin
                            timeout_r <= timeout_r;
                        end
                    end
                end

                ST_HALTED: begin
                    // A request in the same cycle as resume wins; the resume
                    // is dropped and the DM has to retry it.
                    if (req_accept_s) begin
                        if (regno_ok_s) begin
                            state_r   <= ST_ACCESS;
                            ready_r   <= 1'b0;
                            we_r      <= dm_req_we_i;
                            gpr_sel_r <= regno_gpr_s;
                            wdata_r   <= dm_req_wdata_i;
                            gprwr_r   <= dm_req_we_i && regno_gpr_s;
                            csrwr_r   <= dm_req_we_i && !regno_gpr_s;
                            if (regno_gpr_s) begin
                                index_r <= {7'd0, dm_req_regno_i[4:0]};
                            end else begin
                                index_r <= dm_req_regno_i[11:0];
                            end
                        end else begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                        end
                    end else if (dm_resume_req_i) begin
                        state_r     <= ST_RESUME_WAIT;
                        ready_r     <= 1'b0;
                        haltreq_r   <= 1'b0;
                        resumereq_r <= 1'b1;
                    end else begin
                        state_r <= ST_HALTED;
                    end
                end

                ST_ACCESS: begin
                    if (we_r) begin
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_HALTED;
                    end else begin
                        ready_r <= 1'b0;
                        state_r <= ST_READ_WAIT;
                    end
                end

                ST_READ_WAIT: begin
                    resp_valid_r <= 1'b1;
                    state_r      <= ST_HALTED;
                    if (gpr_sel_r) begin
                        resp_rdata_r <= core_gprrdata_i;
                    end else begin
                        resp_rdata_r <= core_csrrdata_i;
                    end
                end

                ST_RESUME_WAIT: begin
                    if (!core_halted_i) begin
                        state_r     <= ST_RUN;
                        resumereq_r <= 1'b0;
                        halted_r    <= 1'b0;
                    end else if (sat_inc(cnt_r) == TIMEOUT_CNT) begin
                        // Core never left halt: give up and stay halted so
                        // the DM can inspect state or retry the resume.
                        timeout_r   <= 1'b1;
                        resumereq_r <= 1'b0;
                        haltreq_r   <= 1'b1;
                        state_r     <= ST_HALTED;
                    end else begin
                        ready_r <= 1'b0;
                        cnt_r   <= sat_inc(cnt_r);
                    end
                end

                default: begin
                    state_r     <= ST_RUN;
                    haltreq_r   <= 1'b0;
                    resumereq_r <= 1'b0;
                    halted_r    <= 1'b0;
                end
            endcase
        end
    end

    assign dm_req_ready_o   = ready_r;
    assign dm_resp_valid_o  = resp_valid_r;
    assign dm_resp_err_o    = resp_err_r;
    assign dm_resp_rdata_o  = resp_rdata_r;
    assign halted_o         = halted_r;
    assign halt_timeout_o   = timeout_r;
    assign core_haltreq_o   = haltreq_r;
    assign core_resumereq_o = resumereq_r;
    assign core_gprwr_o     = gprwr_r;
    assign core_csrwr_o     = csrwr_r;
    assign core_index_o     = index_r;
    assign core_wdata_o     = wdata_r;

endmodule

// File: tb/tb_debug_core_bridge.sv
// tb_debug_core_bridge
//   Directed bench for debug_core_bridge: reset state, halt handshake, a table
//   of register accesses while halted, error responses, resume handshake,
//   halt timeout and asynchronous reset during an access.
module tb_debug_core_bridge;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst_n;
    logic        dm_halt_req_i;
    logic        dm_resume_req_i;
    logic        dm_req_valid_i;
    logic        dm_req_ready_o;
    logic        dm_req_we_i;
    logic [15:0] dm_req_regno_i;
    logic [31:0] dm_req_wdata_i;
    logic        dm_resp_valid_o;
    logic        dm_resp_err_o;
    logic [31:0] dm_resp_rdata_o;
    logic        halted_o;
    logic        halt_timeout_o;
    logic        core_haltreq_o;
    logic        core_resumereq_o;
    logic        core_halted_i;
    logic        core_gprwr_o;
    logic        core_csrwr_o;
    logic [11:0] core_index_o;
    logic [31:0] core_wdata_o;
    logic [31:0] core_gprrdata_i;
    logic [31:0] core_csrrdata_i;

    int n_cmp;
    int n_fail;

    debug_core_bridge #(
        .DATA_BITS(32),
        .REGNO_BITS(16),
        .HALT_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dm_halt_req_i(dm_halt_req_i),
        .dm_resume_req_i(dm_resume_req_i),
        .dm_req_valid_i(dm_req_valid_i),
        .dm_req_ready_o(dm_req_ready_o),
        .dm_req_we_i(dm_req_we_i),
        .dm_req_regno_i(dm_req_regno_i),
        .dm_req_wdata_i(dm_req_wdata_i),
        .dm_resp_valid_o(dm_resp_valid_o),
        .dm_resp_err_o(dm_resp_err_o),
        .dm_resp_rdata_o(dm_resp_rdata_o),
        .halted_o(halted_o),
        .halt_timeout_o(halt_timeout_o),
        .core_haltreq_o(core_haltreq_o),
        .core_resumereq_o(core_resumereq_o),
        .core_halted_i(core_halted_i),
        .core_gprwr_o(core_gprwr_o),
        .core_csrwr_o(core_csrwr_o),
        .core_index_o(core_index_o),
        .core_wdata_o(core_wdata_o),
        .core_gprrdata_i(core_gprrdata_i),
        .core_csrrdata_i(core_csrrdata_i)
    );

    // Free-running 100 MHz core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        resume;
        logic        we;
        logic [15:0] regno;
        logic [31:0] wdata;
        logic [31:0] gpr_rd;
        logic [31:0] csr_rd;
        int          lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        exp_gprwr;
        logic        exp_csrwr;
        logic [11:0] exp_index;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[10];
    vec_t run_vec;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, " ready"},     dm_req_ready_o,   1'b0);
        check1({tag, " resp_valid"}, dm_resp_valid_o, 1'b0);
        check1({tag, " resp_err"},  dm_resp_err_o,    1'b0);
        check32({tag, " rdata"},    dm_resp_rdata_o,  32'h0);
        check1({tag, " halted"},    halted_o,         1'b0);
        check1({tag, " timeout"},   halt_timeout_o,   1'b0);
        check1({tag, " haltreq"},   core_haltreq_o,   1'b0);
        check1({tag, " resumereq"}, core_resumereq_o, 1'b0);
        check1({tag, " gprwr"},     core_gprwr_o,     1'b0);
        check1({tag, " csrwr"},     core_csrwr_o,     1'b0);
        check32({tag, " index"},    32'(core_index_o), 32'h0);
        check32({tag, " wdata"},    core_wdata_o,     32'h0);
    endtask

    // Present a request, wait (bounded) for ready, then pass the accept edge.
    task automatic start_req(input logic resume, input logic we,
                             input logic [15:0] regno, input logic [31:0] wdata);
        int guard;
        guard           = 0;
        dm_req_valid_i  = 1'b1;
        dm_req_we_i     = we;
        dm_req_regno_i  = regno;
        dm_req_wdata_i  = wdata;
        dm_resume_req_i = resume;
        while (!dm_req_ready_o && guard < 10) begin
            tick();
            guard++;
        end
        check1("req_ready", dm_req_ready_o, 1'b1);
        tick();
        dm_req_valid_i  = 1'b0;
        dm_resume_req_i = 1'b0;
    endtask

    // Apply one vector and follow it until its single response.
    task automatic apply_vec(input int id, input vec_t v);
        string pfx;
        pfx = $sformatf("vec%0d", id);
        start_req(v.resume, v.we, v.regno, v.wdata);
        for (int k = 1; k <= v.lat; k++) begin
            if (k == 1) begin
                check1({pfx, " gprwr"}, core_gprwr_o, v.exp_gprwr);
                check1({pfx, " csrwr"}, core_csrwr_o, v.exp_csrwr);
                if (!v.exp_err) begin
                    check32({pfx, " index"}, 32'(core_index_o), 32'(v.exp_index));
                end
                if (v.we && !v.exp_err) begin
                    check32({pfx, " wdata"}, core_wdata_o, v.wdata);
                end
            end
            check1($sformatf("%s resp_valid@%0d", pfx, k), dm_resp_valid_o, (k == v.lat));
            if (k == v.lat) begin
                check1({pfx, " resp_err"}, dm_resp_err_o, v.exp_err);
                check32({pfx, " resp_rdata"}, dm_resp_rdata_o, v.exp_rdata);
            end else begin
                // Core read data is only meaningful in the cycle after the
                // index cycle; junk elsewhere exposes mistimed capture.
                if (k == 2) begin
                    core_gprrdata_i = v.gpr_rd;
                    core_csrrdata_i = v.csr_rd;
                end
                tick();
            end
        end
        core_gprrdata_i = JUNK;
        core_csrrdata_i = JUNK;
        tick();
        check1({pfx, " single_resp"}, dm_resp_valid_o, 1'b0);
        check1({pfx, " no_strobe"}, core_gprwr_o | core_csrwr_o, 1'b0);
        check1({pfx, " resumereq"}, core_resumereq_o, 1'b0);
        check1({pfx, " halted"}, halted_o, v.exp_halted);
        check1({pfx, " ready_after"}, dm_req_ready_o, 1'b1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //            resume we    regno     wdata         gpr_rd        csr_rd        lat err rdata         gwr  cwr  index    halted
        vecs[0] = '{1'b0, 1'b1, 16'h1005, 32'hDEADBEEF, 32'h0,        32'h0,        2, 1'b0, 32'h0,        1'b1, 1'b0, 12'h005, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 16'h0300, 32'h0,        32'h11112222, 32'h00001800, 3, 1'b0, 32'h00001800, 1'b0, 1'b0, 12'h300, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 16'h101F, 32'h0,        32'h12345678, 32'h0F0F0F0F, 3, 1'b0, 32'h12345678, 1'b0, 1'b0, 12'h01F, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 16'h0FFF, 32'hA5A5A5A5, 32'h0,        32'h0,        2, 1'b0, 32'h0,        1'b0, 1'b1, 12'hFFF, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 16'h1000, 32'h00000001, 32'h0,        32'h0,        2, 1'b0, 32'h0,        1'b1, 1'b0, 12'h000, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 16'h1020, 32'h0,        32'h0,        32'h0,        1, 1'b1, 32'h0,        1'b0, 1'b0, 12'h000, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 16'h2000, 32'h55555555, 32'h0,        32'h0,        1, 1'b1, 32'h0,        1'b0, 1'b0, 12'h000, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 16'h0000, 32'h0,        32'h00000000, 32'hCAFEF00D, 3, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 12'h000, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 16'hFFFF, 32'h0,        32'h0,        32'h0,        1, 1'b1, 32'h0,        1'b0, 1'b0, 12'h000, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 16'h1003, 32'h0BADC0DE, 32'h0,        32'h0,        2, 1'b0, 32'h0,        1'b1, 1'b0, 12'h003, 1'b1};
        run_vec = '{1'b0, 1'b0, 16'h1001, 32'h0,        32'h0,        32'h0,        1, 1'b1, 32'h0,        1'b0, 1'b0, 12'h000, 1'b0};

        rst_n           = 1'b0;
        dm_halt_req_i   = 1'b0;
        dm_resume_req_i = 1'b0;
        dm_req_valid_i  = 1'b0;
        dm_req_we_i     = 1'b0;
        dm_req_regno_i  = 16'h0;
        dm_req_wdata_i  = 32'h0;
        core_halted_i   = 1'b0;
        core_gprrdata_i = JUNK;
        core_csrrdata_i = JUNK;

        // Reset state.
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Request while running: immediate error, no core strobe.
        apply_vec(100, run_vec);
        check1("run haltreq", core_haltreq_o, 1'b0);

        // Halt handshake: core acknowledges three clocks after halt_req.
        dm_halt_req_i = 1'b1;
        tick();
        check1("halt haltreq@1", core_haltreq_o, 1'b1);
        check1("halt halted@1", halted_o, 1'b0);
        tick();
        tick();
        check1("halt halted@3", halted_o, 1'b0);
        core_halted_i = 1'b1;
        tick();
        check1("halt halted@4", halted_o, 1'b1);
        check1("halt haltreq@4", core_haltreq_o, 1'b1);

        // Register accesses while halted.
        for (int i = 0; i < 10; i++) begin
            apply_vec(i, vecs[i]);
        end

        // Dropping halt_req while halted changes nothing.
        dm_halt_req_i = 1'b0;
        repeat (3) tick();
        check1("drop halted", halted_o, 1'b1);
        check1("drop haltreq", core_haltreq_o, 1'b1);

        // Resume: core leaves halt two clocks after the pulse.
        dm_resume_req_i = 1'b1;
        tick();
        dm_resume_req_i = 1'b0;
        check1("resume resumereq@1", core_resumereq_o, 1'b1);
        check1("resume haltreq@1", core_haltreq_o, 1'b0);
        check1("resume ready@1", dm_req_ready_o, 1'b0);
        tick();
        check1("resume resumereq@2", core_resumereq_o, 1'b1);
        core_halted_i = 1'b0;
        tick();
        check1("resume resumereq@3", core_resumereq_o, 1'b0);
        check1("resume halted@3", halted_o, 1'b0);
        check1("resume ready@3", dm_req_ready_o, 1'b1);

        // Halt timeout: core never acknowledges.
        dm_halt_req_i = 1'b1;
        tick();
        check1("to haltreq", core_haltreq_o, 1'b1);
        check1("to flag@0", halt_timeout_o, 1'b0);
        repeat (254) tick();
        check1("to flag@254", halt_timeout_o, 1'b0);
        tick();
        check1("to flag@255", halt_timeout_o, 1'b1);
        repeat (45) tick();
        check1("to flag@300", halt_timeout_o, 1'b1);
        check1("to halted@300", halted_o, 1'b0);

        // Request while still waiting for halt: error response.
        run_vec.regno = 16'h0300;
        apply_vec(101, run_vec);
        check1("to flag sticky", halt_timeout_o, 1'b1);

        // Finally halt, start a read and reset in the middle of it.
        core_halted_i = 1'b1;
        tick();
        check1("late halted", halted_o, 1'b1);
        start_req(1'b0, 1'b0, 16'h1003, 32'h0);
        check32("mid index", 32'(core_index_o), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
